// File: rtl/ptw_dmem_port_arb.sv
// rtl/ptw_dmem_port_arb.sv - shares one dcache port between the PTW and the LSU, one access in flight
// PTW has priority; the LSU is forced through after STARVE_MAX consecutive PTW wins while it waits.
module ptw_dmem_port_arb #(
  parameter int ADDR_W     = 40,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ptw_req_valid_i,
  input  logic [ADDR_W-1:0] ptw_req_addr_i,
  input  logic [4:0]        ptw_req_cmd_i,
  input  logic [3:0]        ptw_req_typ_i,
  output logic              ptw_ready_o,
  output logic              ptw_resp_valid_o,
  output logic              ptw_resp_nack_o,
  input  logic              lsu_req_valid_i,
  input  logic [ADDR_W-1:0] lsu_req_addr_i,
  input  logic [4:0]        lsu_req_cmd_i,
  input  logic [3:0]        lsu_req_typ_i,
  input  logic [DATA_W-1:0] lsu_req_data_i,
  output logic              lsu_ready_o,
  output logic              lsu_resp_valid_o,
  output logic              lsu_resp_nack_o,
  output logic [DATA_W-1:0] resp_data_o,
  output logic              dmem_req_valid_o,
  output logic [ADDR_W-1:0] dmem_req_addr_o,
  output logic [4:0]        dmem_req_cmd_o,
  output logic [3:0]        dmem_req_typ_o,
  output logic [DATA_W-1:0] dmem_req_data_o,
  output logic              dmem_req_phys_o,
  input  logic              dmem_ready_i,
  input  logic              dmem_resp_valid_i,
  input  logic              dmem_resp_nack_i,
  input  logic [DATA_W-1:0] dmem_resp_data_i,
  output logic              spurious_resp_o
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, BUSY_PTW, BUSY_LSU} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic               grant_ptw, grant_lsu, accept, resp_any;

  always_comb begin
    state_d          = state_q;
    starve_cnt_d     = starve_cnt_q;
    grant_ptw        = 1'b0;
    grant_lsu        = 1'b0;
    accept           = 1'b0;
    resp_any         = dmem_resp_valid_i | dmem_resp_nack_i;
    ptw_ready_o      = 1'b0;
    ptw_resp_valid_o = 1'b0;
    ptw_resp_nack_o  = 1'b0;
    lsu_ready_o      = 1'b0;
    lsu_resp_valid_o = 1'b0;
    lsu_resp_nack_o  = 1'b0;
    resp_data_o      = '0;
    dmem_req_valid_o = 1'b0;
    dmem_req_addr_o  = '0;
    dmem_req_cmd_o   = '0;
    dmem_req_typ_o   = '0;
    dmem_req_data_o  = '0;
    dmem_req_phys_o  = 1'b0;
    spurious_resp_o  = 1'b0;

    // Outputs are held at zero while reset is asserted, even though the grant is combinational.
    if (!rst_i) begin
      case (state_q)
        IDLE: begin
          grant_lsu = lsu_req_valid_i &&
                      (starve_cnt_q == CNT_W'(STARVE_MAX) || !ptw_req_valid_i);
          grant_ptw = ptw_req_valid_i && !grant_lsu;
          accept    = (grant_ptw || grant_lsu) && dmem_ready_i;
          spurious_resp_o = resp_any;
          if (grant_ptw) begin
            dmem_req_valid_o = 1'b1;
            dmem_req_addr_o  = ptw_req_addr_i;
            dmem_req_cmd_o   = ptw_req_cmd_i;
            dmem_req_typ_o   = ptw_req_typ_i;
            dmem_req_phys_o  = 1'b1;
            ptw_ready_o      = dmem_ready_i;
          end else if (grant_lsu) begin
            dmem_req_valid_o = 1'b1;
            dmem_req_addr_o  = lsu_req_addr_i;
            dmem_req_cmd_o   = lsu_req_cmd_i;
            dmem_req_typ_o   = lsu_req_typ_i;
            dmem_req_data_o  = lsu_req_data_i;
            lsu_ready_o      = dmem_ready_i;
          end
          if (accept) begin
            state_d = grant_ptw ? BUSY_PTW : BUSY_LSU;
            if (grant_lsu)
              starve_cnt_d = '0;
            else if (lsu_req_valid_i && starve_cnt_q != CNT_W'(STARVE_MAX))
              starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end
        end
        BUSY_PTW: begin
          resp_data_o      = dmem_resp_data_i;
          ptw_resp_nack_o  = dmem_resp_nack_i;
          ptw_resp_valid_o = dmem_resp_valid_i && !dmem_resp_nack_i;
          if (resp_any) state_d = IDLE;
        end
        BUSY_LSU: begin
          resp_data_o      = dmem_resp_data_i;
          lsu_resp_nack_o  = dmem_resp_nack_i;
          lsu_resp_valid_o = dmem_resp_valid_i && !dmem_resp_nack_i;
          if (resp_any) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end
endmodule

// File: tb/tb_ptw_dmem_port_arb.sv
// tb/tb_ptw_dmem_port_arb.sv - directed and randomized checks of ptw_dmem_port_arb against an owner/counter model
module tb_ptw_dmem_port_arb;
  localparam int ADDR_W = 40;
  localparam int DATA_W = 64;
  localparam int SMAX   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              pv, lv, rdy, rv, rn;
  logic [ADDR_W-1:0] paddr, laddr;
  logic [4:0]        pcmd, lcmd;
  logic [3:0]        ptyp, ltyp;
  logic [DATA_W-1:0] ldata, rdata;

  logic              ptw_ready, ptw_resp_valid, ptw_resp_nack;
  logic              lsu_ready, lsu_resp_valid, lsu_resp_nack;
  logic [DATA_W-1:0] resp_data, dreq_data;
  logic              dreq_valid, dreq_phys, spurious;
  logic [ADDR_W-1:0] dreq_addr;
  logic [4:0]        dreq_cmd;
  logic [3:0]        dreq_typ;

  int checks = 0;
  int failures = 0;

  // model: who owns the port (0 none, 1 PTW, 2 LSU) and how long the LSU has been passed over
  int m_owner = 0, m_starve = 0, n_owner = 0, n_starve = 0;
  bit g_q[$];

  ptw_dmem_port_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(SMAX)) dut (
    .clk_i(clk), .rst_i(rst),
    .ptw_req_valid_i(pv), .ptw_req_addr_i(paddr), .ptw_req_cmd_i(pcmd), .ptw_req_typ_i(ptyp),
    .ptw_ready_o(ptw_ready), .ptw_resp_valid_o(ptw_resp_valid), .ptw_resp_nack_o(ptw_resp_nack),
    .lsu_req_valid_i(lv), .lsu_req_addr_i(laddr), .lsu_req_cmd_i(lcmd), .lsu_req_typ_i(ltyp),
    .lsu_req_data_i(ldata),
    .lsu_ready_o(lsu_ready), .lsu_resp_valid_o(lsu_resp_valid), .lsu_resp_nack_o(lsu_resp_nack),
    .resp_data_o(resp_data),
    .dmem_req_valid_o(dreq_valid), .dmem_req_addr_o(dreq_addr), .dmem_req_cmd_o(dreq_cmd),
    .dmem_req_typ_o(dreq_typ), .dmem_req_data_o(dreq_data), .dmem_req_phys_o(dreq_phys),
    .dmem_ready_i(rdy), .dmem_resp_valid_i(rv), .dmem_resp_nack_i(rn),
    .dmem_resp_data_i(rdata), .spurious_resp_o(spurious)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Settle combinational outputs, compare against the model, and compute the model's next state.
  task automatic check();
    int               win;
    logic [ADDR_W-1:0] e_addr;
    logic [4:0]        e_cmd;
    logic [3:0]        e_typ;
    logic [DATA_W-1:0] e_data;
    logic e_dv, e_phys, e_pr, e_lr, e_pv, e_pn, e_lv, e_ln, e_sp;
    #1;
    win = 0; e_addr = '0; e_cmd = '0; e_typ = '0; e_data = '0;
    e_dv = 0; e_phys = 0; e_pr = 0; e_lr = 0; e_pv = 0; e_pn = 0; e_lv = 0; e_ln = 0; e_sp = 0;
    n_owner = m_owner; n_starve = m_starve;
    if (rst) begin
      n_owner = 0; n_starve = 0;
    end else if (m_owner == 0) begin
      e_sp = rv | rn;
      if (lv && (m_starve >= SMAX || !pv)) win = 2;
      else if (pv) win = 1;
      if (win == 1) begin
        e_dv = 1; e_addr = paddr; e_cmd = pcmd; e_typ = ptyp; e_phys = 1; e_pr = rdy;
      end else if (win == 2) begin
        e_dv = 1; e_addr = laddr; e_cmd = lcmd; e_typ = ltyp; e_data = ldata; e_lr = rdy;
      end
      if (win != 0 && rdy) begin
        n_owner = win;
        if (win == 2) n_starve = 0;
        else if (lv) n_starve = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
        g_q.push_back(win == 1);
      end
    end else if (rv | rn) begin
      if (m_owner == 1) begin e_pn = rn; e_pv = rv & ~rn; end
      else              begin e_ln = rn; e_lv = rv & ~rn; end
      n_owner = 0;
    end
    chk("req_valid", 64'(dreq_valid), 64'(e_dv));
    chk("req_addr",  64'(dreq_addr),  64'(e_addr));
    chk("req_cmd",   64'(dreq_cmd),   64'(e_cmd));
    chk("req_typ",   64'(dreq_typ),   64'(e_typ));
    chk("req_data",  dreq_data,       e_data);
    chk("req_phys",  64'(dreq_phys),  64'(e_phys));
    chk("ptw_ready", 64'(ptw_ready),  64'(e_pr));
    chk("lsu_ready", 64'(lsu_ready),  64'(e_lr));
    chk("ptw_rvld",  64'(ptw_resp_valid), 64'(e_pv));
    chk("ptw_nack",  64'(ptw_resp_nack),  64'(e_pn));
    chk("lsu_rvld",  64'(lsu_resp_valid), 64'(e_lv));
    chk("lsu_nack",  64'(lsu_resp_nack),  64'(e_ln));
    chk("spurious",  64'(spurious),   64'(e_sp));
    if (e_pv | e_lv) chk("resp_data", resp_data, rdata);
  endtask

  task automatic advance();
    m_owner = n_owner; m_starve = n_starve;
    @(negedge clk);
  endtask

  task automatic step();
    check();
    advance();
  endtask

  task automatic idle_inputs();
    pv = 0; lv = 0; rdy = 1; rv = 0; rn = 0;
    paddr = '0; laddr = '0; pcmd = '0; lcmd = '0; ptyp = '0; ltyp = '0; ldata = '0; rdata = '0;
  endtask

  initial begin
    idle_inputs();
    rst = 1; pv = 1; lv = 1; ldata = 64'hDEAD_BEEF_0123_4567;
    check();
    chk("rst_req_valid", 64'(dreq_valid), 64'd0);
    chk("rst_lsu_ready", 64'(lsu_ready), 64'd0);
    advance();
    step();
    rst = 0;

    // both valid after release: PTW wins, no store data on the PTW path
    rdy = 0; check();
    chk("ptw_first_phys", 64'(dreq_phys), 64'd1);
    chk("ptw_first_data", dreq_data, 64'd0);
    advance();

    // PTW read, response two cycles after accept
    lv = 0; rdy = 1; paddr = 40'h80001008; pcmd = 5'b00000; ptyp = 4'b0011;
    check();
    chk("pte_addr", 64'(dreq_addr), 64'h80001008);
    chk("pte_accept", 64'(ptw_ready), 64'd1);
    advance();
    pv = 0; step();
    rv = 1; rdata = 64'h200000CF; check();
    chk("pte_resp_valid", 64'(ptw_resp_valid), 64'd1);
    chk("pte_resp_data", resp_data, 64'h200000CF);
    chk("pte_lsu_quiet", 64'(lsu_resp_valid), 64'd0);
    advance();
    rv = 0; step();

    // starvation: both always valid, instant responses
    rst = 1; step(); rst = 0;
    g_q.delete();
    pv = 1; lv = 1; rdy = 1; rv = 1;
    paddr = 40'h1000; laddr = 40'h2000; ldata = 64'h55;
    for (int i = 0; i < 36; i++) step();
    chk("starve_grants", 64'(g_q.size()), 64'd18);
    for (int k = 0; k < 18 && k < g_q.size(); k++)
      chk($sformatf("starve_grant%0d", k), 64'(g_q[k]), (k % 9 == 8) ? 64'd0 : 64'd1);
    idle_inputs(); step();

    // LSU nacked with valid also set
    lv = 1; laddr = 40'h3040; ldata = 64'hABCD; step();
    lv = 0; rv = 1; rn = 1; check();
    chk("lsu_nack", 64'(lsu_resp_nack), 64'd1);
    chk("lsu_nack_novalid", 64'(lsu_resp_valid), 64'd0);
    advance();
    rv = 0; rn = 0; lv = 1; rdy = 0; check();
    chk("lsu_back_idle", 64'(dreq_valid), 64'd1);
    advance();

    // PTW held by dcache backpressure; LSU appears without starvation
    rst = 1; step(); rst = 0;
    idle_inputs(); pv = 1; paddr = 40'h7700; rdy = 0;
    for (int i = 0; i < 3; i++) step();
    lv = 1; laddr = 40'h9900; check();
    chk("bp_grant_ptw", 64'(dreq_phys), 64'd1);
    chk("bp_addr_stable", 64'(dreq_addr), 64'h7700);
    advance();
    rdy = 1; step();
    idle_inputs(); rv = 1; step();

    // response with nothing in flight
    rv = 1; check();
    chk("spur_pulse", 64'(spurious), 64'd1);
    advance();
    rv = 0; step();

    // async reset during an access, late response is spurious
    pv = 1; paddr = 40'h4440; step();
    pv = 0; rst = 1; check();
    chk("mid_rst_quiet", 64'(spurious), 64'd0);
    advance();
    rst = 0; rv = 1; check();
    chk("late_resp_spur", 64'(spurious), 64'd1);
    chk("late_resp_unrouted", 64'(ptw_resp_valid), 64'd0);
    advance();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(99) == 0);
      pv    = ($urandom_range(99) < 60);
      lv    = ($urandom_range(99) < 50);
      rdy   = ($urandom_range(99) < 70);
      rv    = ($urandom_range(99) < 40);
      rn    = ($urandom_range(99) < 15);
      paddr = 40'({$urandom(), $urandom()});
      laddr = 40'({$urandom(), $urandom()});
      pcmd  = 5'($urandom()); lcmd = 5'($urandom());
      ptyp  = 4'($urandom()); ltyp = 4'($urandom());
      ldata = {$urandom(), $urandom()};
      rdata = {$urandom(), $urandom()};
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
